// File: rtl/nmi2apb_bridge_if.sv
// Bus bundle between the SoC decoder, nmi2apb_bridge and its APB slave.
// The bridge connects through 'master' (it masters APB); the system side uses 'slave'.
interface nmi2apb_bridge_if;
  logic        nmi_valid;
  logic [31:0] nmi_addr;
  logic [31:0] nmi_wdata;
  logic [3:0]  nmi_wstrb;
  logic [31:0] nmi_rdata;
  logic        nmi_ready;

  logic [31:0] apb_paddr;
  logic [2:0]  apb_pprot;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_pwrite;
  logic [31:0] apb_pwdata;
  logic [3:0]  apb_pstrb;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic        apb_pslverr;

  modport master (
    input  nmi_valid, nmi_addr, nmi_wdata, nmi_wstrb,
    output nmi_rdata, nmi_ready,
    output apb_paddr, apb_pprot, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
    input  apb_prdata, apb_pready, apb_pslverr
  );

  modport slave (
    output nmi_valid, nmi_addr, nmi_wdata, nmi_wstrb,
    input  nmi_rdata, nmi_ready,
    input  apb_paddr, apb_pprot, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
    output apb_prdata, apb_pready, apb_pslverr
  );
endinterface

// File: rtl/nmi2apb_bridge.sv
// NMI-to-APB bridge: one APB transfer per NMI request, registered outputs, sticky error flag.
// Define APB_TIMEOUT_EN to add the ACCESS-phase wait-state timeout.
module nmi2apb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  nmi2apb_bridge_if.master        bus,
  input  logic                    err_clr_i,
  output logic                    err_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("nmi2apb_bridge: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  typedef struct packed {
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
  } regs_t;

  state_e state_q, state_d;
  regs_t  r_q, r_d;
  logic   end_xfer, end_err;

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    r_d        = r_q;
    r_d.ready  = 1'b0;
    r_d.rdata  = '0;
    r_d.err    = r_q.err & ~err_clr_i;
    end_xfer   = 1'b0;
    end_err    = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      IDLE: if (bus.nmi_valid) begin
        r_d.paddr   = bus.nmi_addr;
        r_d.pwdata  = bus.nmi_wdata;
        r_d.pwrite  = |bus.nmi_wstrb;
        // An all-zero strobe is a read, so the raw strobe already reads as 0.
        r_d.pstrb   = bus.nmi_wstrb;
        r_d.psel    = 1'b1;
        r_d.penable = 1'b0;
        state_d     = SETUP;
`ifdef APB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      SETUP: begin
        r_d.penable = 1'b1;
        state_d     = ACCESS;
      end
      ACCESS: begin
        if (bus.apb_pready) begin
          end_xfer = 1'b1;
          end_err  = bus.apb_pslverr;
        end
`ifdef APB_TIMEOUT_EN
        // A pready in the terminal-count cycle wins and completes normally.
        else if (cnt_q == TimeoutLast) begin
          end_xfer = 1'b1;
          end_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (end_xfer) begin
      state_d     = DONE;
      r_d.psel    = 1'b0;
      r_d.penable = 1'b0;
      r_d.ready   = 1'b1;
      r_d.rdata   = r_q.pwrite ? '0 : (end_err ? ERR_RDATA : bus.apb_prdata);
      // Setting the flag overrides a same-cycle clear.
      if (end_err) r_d.err = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      r_q     <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      r_q     <= r_d;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.nmi_rdata   = r_q.rdata;
  assign bus.nmi_ready   = r_q.ready;
  assign bus.apb_paddr   = r_q.paddr;
  assign bus.apb_pprot   = 3'b000;
  assign bus.apb_psel    = r_q.psel;
  assign bus.apb_penable = r_q.penable;
  assign bus.apb_pwrite  = r_q.pwrite;
  assign bus.apb_pwdata  = r_q.pwdata;
  assign bus.apb_pstrb   = r_q.pstrb;
  assign err_o           = r_q.err;

endmodule

// File: tb/tb_nmi2apb_bridge.sv
// Self-checking bench for nmi2apb_bridge: directed cases plus randomized transfers
// scored against a transaction-level model of latency, read data and error flag.
module tb_nmi2apb_bridge;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk_i     = 1'b0;
  logic rst_n_i   = 1'b0;
  logic err_clr_i = 1'b0;
  logic err_o;

  nmi2apb_bridge_if bus();

  nmi2apb_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .bus       (bus),
    .err_clr_i (err_clr_i),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  logic err_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic pulse_clear();
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    err_exp   = 1'b0;
    check("err_clear", 32'(err_o), 32'(err_exp));
  endtask

  // One NMI request against a scripted slave that asserts pready on ACCESS cycle waits+1.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input int waits, input logic [31:0] prd,
                      input logic slverr, input logic clr_at_end, input logic drop_valid,
                      output int ready_cyc);
    logic        wr;
    logic        tmo;
    int          exp_lat, exp_acc;
    logic [31:0] exp_rd;
    int          n, acc;
    logic        seen_ready, stable, rzero, first, first_pen;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_strb;
    logic        s_write;

    wr  = |wstrb;
    tmo = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo = (waits >= TO);
`endif
    if (tmo) begin
      exp_acc = TO;
      exp_lat = TO + 2;
      exp_rd  = wr ? 32'h0 : ERR;
    end else begin
      exp_acc = waits + 1;
      exp_lat = waits + 3;
      exp_rd  = wr ? 32'h0 : (slverr ? ERR : prd);
    end
    if (tmo || slverr) err_exp = 1'b1;
    else if (clr_at_end) err_exp = 1'b0;

    bus.nmi_valid = 1'b1;
    bus.nmi_addr  = addr;
    bus.nmi_wdata = wdata;
    bus.nmi_wstrb = wstrb;
    n = 0; acc = 0;
    seen_ready = 1'b0; stable = 1'b1; rzero = 1'b1; first = 1'b1; first_pen = 1'bx;
    s_addr = 'x; s_wdata = 'x; s_strb = 'x; s_write = 1'bx;

    while (!seen_ready && n < 64) begin
      step();
      n++;
      bus.apb_pready  = 1'b0;
      bus.apb_pslverr = 1'b0;
      bus.apb_prdata  = $urandom();
      err_clr_i       = 1'b0;
      if (bus.nmi_ready) begin
        seen_ready = 1'b1;
      end else begin
        if (bus.nmi_rdata !== 32'h0) rzero = 1'b0;
        if (bus.apb_psel) begin
          if (first) begin
            first     = 1'b0;
            first_pen = bus.apb_penable;
            s_addr    = bus.apb_paddr;
            s_wdata   = bus.apb_pwdata;
            s_strb    = bus.apb_pstrb;
            s_write   = bus.apb_pwrite;
          end else if ({bus.apb_paddr, bus.apb_pwdata, bus.apb_pstrb, bus.apb_pwrite}
                       !== {s_addr, s_wdata, s_strb, s_write}) begin
            stable = 1'b0;
          end
          if (bus.apb_penable) begin
            acc++;
            if (acc == waits + 1) begin
              bus.apb_pready  = 1'b1;
              bus.apb_pslverr = slverr;
              bus.apb_prdata  = prd;
              err_clr_i       = clr_at_end;
            end
          end
        end
        if (drop_valid && !first) bus.nmi_valid = 1'b0;
      end
    end
    bus.nmi_valid = 1'b0;
    ready_cyc = cyc;

    check({tag, "_latency"},   32'(n),              32'(exp_lat));
    check({tag, "_rdata"},     bus.nmi_rdata,       exp_rd);
    check({tag, "_access"},    32'(acc),            32'(exp_acc));
    check({tag, "_setup_pen"}, 32'(first_pen),      32'h0);
    check({tag, "_stable"},    32'(stable),         32'h1);
    check({tag, "_paddr"},     s_addr,              addr);
    check({tag, "_pwrite"},    32'(s_write),        32'(wr));
    check({tag, "_pstrb"},     32'(s_strb),         32'(wr ? wstrb : 4'h0));
    if (wr) check({tag, "_pwdata"}, s_wdata, wdata);
    check({tag, "_rdata_idle"}, 32'(rzero),         32'h1);
    check({tag, "_done_psel"}, 32'(bus.apb_psel),   32'h0);
    check({tag, "_err"},       32'(err_o),          32'(err_exp));

    step();
    check({tag, "_pulse_len"}, 32'(bus.nmi_ready),  32'h0);
    check({tag, "_rdata_zero"}, bus.nmi_rdata,      32'h0);
    check({tag, "_idle_psel"}, 32'(bus.apb_psel),   32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc1, rc2;
    logic ready_seen;

    bus.nmi_valid = 1'b0; bus.nmi_addr = '0; bus.nmi_wdata = '0; bus.nmi_wstrb = '0;
    bus.apb_prdata = '0; bus.apb_pready = 1'b0; bus.apb_pslverr = 1'b0;

    repeat (2) step();
    check("rst_psel",    32'(bus.apb_psel),    32'h0);
    check("rst_penable", 32'(bus.apb_penable), 32'h0);
    check("rst_ready",   32'(bus.nmi_ready),   32'h0);
    check("rst_rdata",   bus.nmi_rdata,        32'h0);
    check("rst_paddr",   bus.apb_paddr,        32'h0);
    check("rst_pprot",   32'(bus.apb_pprot),   32'h0);
    check("rst_err",     32'(err_o),           32'h0);
    rst_n_i = 1'b1;
    step();

    xfer("rd0", 32'h1000_0004, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, rc1);
    xfer("wr2", 32'h1000_0010, 32'hA5A5_0F0F, 4'b0011, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, rc1);

    xfer("slverr", 32'h1000_0020, 32'h0, 4'h0, 1, 32'h0BAD_0BAD, 1'b1, 1'b0, 1'b0, rc1);
    step();
    check("err_held", 32'(err_o), 32'h1);
    pulse_clear();
    xfer("clr_vs_set", 32'h1000_0024, 32'h0, 4'h0, 0, 32'h1111_2222, 1'b1, 1'b1, 1'b0, rc1);
    pulse_clear();

    xfer("b2b_a", 32'h1000_0100, 32'h0, 4'h0, 0, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0, rc1);
    xfer("b2b_b", 32'h1000_0104, 32'h0, 4'h0, 0, 32'hCAFE_0002, 1'b0, 1'b0, 1'b0, rc2);
    check("b2b_spacing", 32'(rc2 - rc1), 32'd4);

    xfer("drop_valid", 32'h1000_0200, 32'h7777_8888, 4'b1111, 1, 32'h0, 1'b0, 1'b0, 1'b1, rc1);

`ifdef APB_TIMEOUT_EN
    xfer("tmo_rd", 32'h1000_0300, 32'h0, 4'h0, 1000, 32'h0, 1'b0, 1'b0, 1'b0, rc1);
    pulse_clear();
    xfer("tmo_edge", 32'h1000_0304, 32'h0, 4'h0, TO - 1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, rc1);
    xfer("tmo_wr", 32'h1000_0308, 32'h0123_4567, 4'b1000, 1000, 32'h0, 1'b0, 1'b0, 1'b0, rc1);
    pulse_clear();
`endif

    for (int i = 0; i < 24; i++) begin
      logic [3:0] ws;
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      if ($urandom_range(0, 3) == 0) pulse_clear();
      xfer($sformatf("rnd%0d", i), $urandom(), $urandom(), ws, int'($urandom_range(0, 5)),
           $urandom(), ($urandom_range(0, 7) == 0), 1'b0, ($urandom_range(0, 5) == 0), rc1);
    end

    bus.nmi_valid = 1'b1; bus.nmi_addr = 32'h1000_0400; bus.nmi_wstrb = 4'h0;
    step();
    step();
    bus.nmi_valid = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    err_exp = 1'b0;
    check("arst_psel",    32'(bus.apb_psel),    32'h0);
    check("arst_penable", 32'(bus.apb_penable), 32'h0);
    check("arst_paddr",   bus.apb_paddr,        32'h0);
    check("arst_ready",   32'(bus.nmi_ready),   32'h0);
    check("arst_err",     32'(err_o),           32'h0);
    ready_seen = 1'b0;
    repeat (3) begin
      step();
      if (bus.nmi_ready) ready_seen = 1'b1;
    end
    rst_n_i = 1'b1;
    repeat (2) begin
      step();
      if (bus.nmi_ready) ready_seen = 1'b1;
    end
    check("arst_no_pulse", 32'(ready_seen), 32'h0);
    xfer("post_rst", 32'h1000_0404, 32'h0, 4'h0, 0, 32'h600D_F00D, 1'b0, 1'b0, 1'b0, rc1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
